// File: rtl/lcd_rd.sv
// lcd_rd: HD44780-style LCD read controller with optional busy-flag polling
module lcd_rd #(
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 24,
  parameter int HOLD_CYC  = 4,
  parameter int GAP_CYC   = 8,
  parameter int MAX_POLLS = 255
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_rs_i,
  input  logic       req_poll_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  output logic [7:0] rd_data_o,
  output logic       rd_rs_o,
  output logic       rd_timeout_o,
  output logic       rd_valid_o,
  input  logic       rd_ready_i,
  output logic       rs_o,
  output logic       rw_o,
  output logic       en_o,
  input  logic [7:0] lcd_data_i
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP, RESP} state_t;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_poll;
  logic [7:0]  r_polls;
  logic [15:0] w_len;
  logic        w_done;
  logic        w_again;
  assign req_ready_o = (r_state == IDLE);
  // Length of the current timed phase and whether this is its final clock
  always_comb begin
    w_len   = r_state == SETUP  ? 16'(SETUP_CYC) :
              r_state == STROBE ? 16'(EN_CYC)    :
              r_state == HOLD   ? 16'(HOLD_CYC)  :
              r_state == GAP    ? 16'(GAP_CYC)   : 16'd1;
    w_done  = (r_cnt == w_len - 16'd1);
    w_again = r_poll && rd_data_o[7] && (r_polls < 8'(MAX_POLLS));
  end
  // Phase sequencer with registered LCD strobes and response outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_poll       <= 1'b0;
      r_polls      <= '0;
      rs_o         <= 1'b0;
      rw_o         <= 1'b0;
      en_o         <= 1'b0;
      rd_data_o    <= '0;
      rd_rs_o      <= 1'b0;
      rd_timeout_o <= 1'b0;
      rd_valid_o   <= 1'b0;
    end else begin
      r_cnt <= (r_state == IDLE || r_state == RESP || w_done) ? 16'd0 : r_cnt + 16'd1;
      case (r_state)
        IDLE: if (req_valid_i) begin
          rs_o    <= req_rs_i;
          r_poll  <= req_poll_i & ~req_rs_i;
          r_polls <= '0;
          rw_o    <= 1'b1;
          r_state <= SETUP;
        end
        SETUP: if (w_done) begin
          en_o    <= 1'b1;
          r_state <= STROBE;
        end
        STROBE: if (w_done) begin
          en_o      <= 1'b0;
          rd_data_o <= lcd_data_i;
          r_polls   <= r_polls + 8'd1;
          r_state   <= HOLD;
        end
        HOLD: if (w_done) begin
          if (w_again) r_state <= GAP;
          else begin
            rw_o         <= 1'b0;
            rd_valid_o   <= 1'b1;
            rd_rs_o      <= rs_o;
            rd_timeout_o <= r_poll & rd_data_o[7];
            r_state      <= RESP;
          end
        end
        GAP: if (w_done) r_state <= SETUP;
        RESP: if (rd_ready_i) begin
          rd_valid_o <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_rd.sv
// tb_lcd_rd: directed self-checking bench for lcd_rd
module tb_lcd_rd;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_rs = 1'b0, req_poll = 1'b0, req_valid = 1'b0, req_valid3 = 1'b0, rd_ready = 1'b1;
  logic [7:0] lcd = 8'h00;
  logic req_ready, rd_rs, rd_to, rd_valid, rs, rw, en;
  logic req_ready3, rd_rs3, rd_to3, rd_valid3, rs3, rw3, en3;
  logic [7:0] rd_data, rd_data3;
  logic sel3 = 1'b0;
  wire m_en = sel3 ? en3 : en;
  wire m_rw = sel3 ? rw3 : rw;
  wire m_valid = sel3 ? rd_valid3 : rd_valid;
  wire [7:0] m_data = sel3 ? rd_data3 : rd_data;
  wire m_rs = sel3 ? rd_rs3 : rd_rs;
  wire m_to = sel3 ? rd_to3 : rd_to;
  wire m_lrs = sel3 ? rs3 : rs;
  int checks = 0, failures = 0;
  int en_cnt, rw_cnt, pulses, t_valid, min_low, low_run;
  logic [7:0] v_data;
  logic v_rs, v_to, v_lrs, prev;

  lcd_rd dut (.clk_i(clk), .rst_n_i(rst_n), .req_rs_i(req_rs), .req_poll_i(req_poll),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .rd_data_o(rd_data), .rd_rs_o(rd_rs),
    .rd_timeout_o(rd_to), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rs_o(rs),
    .rw_o(rw), .en_o(en), .lcd_data_i(lcd));

  lcd_rd #(.MAX_POLLS(3)) dut3 (.clk_i(clk), .rst_n_i(rst_n), .req_rs_i(req_rs),
    .req_poll_i(req_poll), .req_valid_i(req_valid3), .req_ready_o(req_ready3),
    .rd_data_o(rd_data3), .rd_rs_o(rd_rs3), .rd_timeout_o(rd_to3), .rd_valid_o(rd_valid3),
    .rd_ready_i(rd_ready), .rs_o(rs3), .rw_o(rw3), .en_o(en3), .lcd_data_i(lcd));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic r, input logic p, input logic [7:0] d1, input logic [7:0] d2, input int n_sw);
    req_rs = r; req_poll = p; lcd = d1;
    if (sel3) req_valid3 = 1'b1; else req_valid = 1'b1;
    step();
    req_valid = 1'b0; req_valid3 = 1'b0;
    v_lrs = m_lrs;
    en_cnt = 0; rw_cnt = int'(m_rw); pulses = 0; t_valid = -1; min_low = 1000; low_run = 0;
    for (int k = 1; k <= 400 && t_valid < 0; k++) begin
      prev = m_en;
      step();
      if (m_en) begin
        en_cnt++;
        if (!prev) begin
          pulses++;
          if (pulses > 1 && low_run < min_low) min_low = low_run;
        end
        low_run = 0;
      end else begin
        low_run++;
        if (prev && pulses == n_sw) lcd = d2;
      end
      rw_cnt += int'(m_rw);
      if (m_valid) begin
        t_valid = k; v_data = m_data; v_rs = m_rs; v_to = m_to;
      end
    end
  endtask

  initial begin
    int bad_v, bad_d, bad_r, seen;
    step(); step();
    chk("rst_en", en, 1'b0);
    chk("rst_rw", rw, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, 8'h00);
    rst_n = 1'b1;
    step();
    // data read
    run(1'b1, 1'b0, 8'h41, 8'h41, 99);
    chk("data_rs_o", v_lrs, 1'b1);
    chk("data_rw_cnt", rw_cnt, 32);
    chk("data_en_cnt", en_cnt, 24);
    chk("data_lat", t_valid, 32);
    chk("data_byte", v_data, 8'h41);
    chk("data_rd_rs", v_rs, 1'b1);
    chk("data_to", v_to, 1'b0);
    step();
    chk("data_back_idle", req_ready, 1'b1);
    step();
    // BF read without polling
    run(1'b0, 1'b0, 8'h8C, 8'h8C, 99);
    chk("bf_pulses", pulses, 1);
    chk("bf_byte", v_data, 8'h8C);
    chk("bf_to", v_to, 1'b0);
    chk("bf_rd_rs", v_rs, 1'b0);
    step(); step();
    // poll flag ignored on RAM reads
    run(1'b1, 1'b1, 8'h80, 8'h80, 99);
    chk("rampoll_pulses", pulses, 1);
    chk("rampoll_to", v_to, 1'b0);
    step(); step();
    // poll until BF clears
    run(1'b0, 1'b1, 8'h85, 8'h05, 3);
    chk("poll_pulses", pulses, 4);
    chk("poll_gap_low", min_low, 16);
    chk("poll_byte", v_data, 8'h05);
    chk("poll_to", v_to, 1'b0);
    chk("poll_lat", t_valid, 152);
    step(); step();
    // poll timeout on the MAX_POLLS=3 instance
    sel3 = 1'b1;
    chk("to_ready", req_ready3, 1'b1);
    run(1'b0, 1'b1, 8'h80, 8'h80, 99);
    chk("to_pulses", pulses, 3);
    chk("to_byte", v_data, 8'h80);
    chk("to_flag", v_to, 1'b1);
    chk("to_lat", t_valid, 112);
    sel3 = 1'b0;
    step(); step();
    // back-pressure
    rd_ready = 1'b0;
    run(1'b1, 1'b0, 8'h5A, 8'h5A, 99);
    chk("bp_lat", t_valid, 32);
    bad_v = 0; bad_d = 0; bad_r = 0;
    req_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      lcd = ~lcd;
      step();
      if (rd_valid !== 1'b1) bad_v++;
      if (rd_data !== 8'h5A) bad_d++;
      if (req_ready !== 1'b0) bad_r++;
    end
    req_valid = 1'b0;
    chk("bp_valid_drop", bad_v, 0);
    chk("bp_data_change", bad_d, 0);
    chk("bp_ready_high", bad_r, 0);
    chk("bp_en_quiet", en, 1'b0);
    rd_ready = 1'b1;
    step();
    chk("bp_release_valid", rd_valid, 1'b0);
    chk("bp_release_ready", req_ready, 1'b1);
    step();
    chk("bp_no_new_req", rw, 1'b0);
    // reset in the middle of the strobe
    req_rs = 1'b1; lcd = 8'h41; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (13) step();
    chk("mid_en_high", en, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_en", en, 1'b0);
    chk("mid_rst_rw", rw, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (rd_valid) seen++;
    end
    chk("mid_no_resp", seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
